fifo_rd_streamer: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 18 +
 rtl/fifo_rd_skid.sv | 80 ++++++++
 rtl/fifo_rd_streamer.sv | 176 +++++++++++++++++
 tb/tb_fifo_rd_streamer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared constants and types for the FIFO read-side streamer.
//   SKID_DEPTH : number of words the output skid buffer can hold
//   OCC_W      : width of the skid occupancy count (0..SKID_DEPTH)
//   BEAT_W     : width of the burst beat counter
//   fifo_rd_state_t : streamer control state (IDLE / RUN / DRAIN)
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int BEAT_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fifo_rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry register buffer that catches words arriving from
// the FIFO RAM one cycle after the read strobe and presents them in order.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   push       in   write push_data at the tail this cycle
//   push_data  in   word to store
//   pop        in   remove the head word this cycle (ignored when empty)
//   occ        out  number of stored words, 0..SKID_DEPTH
//   head_valid out  head entry holds a word (occ != 0)
//   head_data  out  head word (entry 0)
//
// Entry 0 is always the head, so the head data comes straight from a flop.
// A push while full with no pop is dropped; the read issue logic upstream
// never lets that happen.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic              head_valid,
  output logic [DWIDTH-1:0] head_data
);

  typedef logic [OCC_W-1:0] occ_t;

  logic [DWIDTH-1:0] entry0_q;
  logic [DWIDTH-1:0] entry1_q;
  occ_t              occ_q;
  logic              pop_eff;

  assign pop_eff = pop & (occ_q != occ_t'(0));

  always_ff @(posedge clk) begin
    if (reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= '0;
    end else begin
      unique case ({push, pop_eff})
        2'b10: begin
          if (occ_q == occ_t'(0)) begin
            entry0_q <= push_data;
            occ_q    <= occ_q + occ_t'(1);
          end else if (occ_q == occ_t'(1)) begin
            entry1_q <= push_data;
            occ_q    <= occ_q + occ_t'(1);
          end
        end
        2'b01: begin
          entry0_q <= entry1_q;
          occ_q    <= occ_q - occ_t'(1);
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy unchanged, order kept.
          if (occ_q == occ_t'(1)) begin
            entry0_q <= push_data;
          end else begin
            entry0_q <= entry1_q;
            entry1_q <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign occ        = occ_q;
  assign head_valid = (occ_q != occ_t'(0));
  assign head_data  = entry0_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side engine for the dual-clock FIFO. Issues FIFO
// reads from the empty flag, absorbs the one-cycle RAM read latency in a
// two-entry skid buffer and presents the words as a valid/ready stream with
// burst framing (m_last on every BURST-th word).
//
// Parameters:
//   DWIDTH  data word width (matches the FIFO)
//   BURST   words per burst, 1..256
//
// Ports:
//   rd_clk      in   FIFO read clock
//   reset       in   synchronous active-high reset
//   enable      in   permits new FIFO reads when high
//   fifo_empty  in   FIFO empty flag
//   fifo_read   out  FIFO read strobe, one word per high cycle
//   fifo_q      in   FIFO read data, valid the cycle after fifo_read
//   m_valid     out  output word valid
//   m_ready     in   downstream accepts the word
//   m_data      out  output word
//   m_last      out  last word of the current burst
//   busy        out  a read is in flight or the skid buffer holds words
//   state       out  current control state (debug visibility)
//   pop_count   out  [FIFO_RD_STATS_EN only] accepted words, wrapping
//   stall_count out  [FIFO_RD_STATS_EN only] cycles with m_valid & ~m_ready
//
// Optional feature macro: FIFO_RD_STATS_EN adds the two statistics counters.
//
// Handshake: a word transfers on every rd_clk edge where m_valid and m_ready
// are both high; once m_valid is high, m_valid/m_data/m_last hold until that
// transfer, and m_valid never depends on m_ready.
module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int BURST  = 16
) (
  input  logic              rd_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output fifo_rd_state_t    state
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]       pop_count,
  output logic [31:0]       stall_count
`endif
);

  typedef logic [OCC_W:0]    commit_t;
  typedef logic [BEAT_W-1:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(BURST - 1);

  logic             inflight_q;
  logic [OCC_W-1:0] occ;
  logic             pop;
  commit_t          committed;
  commit_t          limit;
  beat_t            beat_q;
  fifo_rd_state_t   state_q;
  fifo_rd_state_t   state_d;

  assign pop = m_valid & m_ready;

  // Words already owned by the streamer (buffered plus in flight), less the
  // one leaving this cycle, must stay below the buffer depth so the word a
  // new read returns next cycle always has a slot.
  assign committed = commit_t'(occ) + commit_t'(inflight_q);
  assign limit     = commit_t'(SKID_DEPTH) + commit_t'(pop);
  assign fifo_read = enable & ~fifo_empty & (committed < limit);

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_read;
    end
  end

  fifo_rd_skid #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (fifo_q),
    .pop       (pop),
    .occ       (occ),
    .head_valid(m_valid),
    .head_data (m_data)
  );

  assign busy = inflight_q | (occ != '0);

  // Beat counter survives enable going low so a burst resumes mid-way.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      beat_q <= '0;
    end else if (pop) begin
      if (beat_q == LAST_BEAT) begin
        beat_q <= '0;
      end else begin
        beat_q <= beat_q + beat_t'(1);
      end
    end
  end

  // Qualified by m_valid so the flag is low whenever no word is presented.
  assign m_last = m_valid & (beat_q == LAST_BEAT);

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_read) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = busy ? DRAIN : IDLE;
        end else if (!busy && !fifo_read) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (!busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

`ifdef FIFO_RD_STATS_EN
  logic [31:0] pop_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      pop_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (pop) begin
        pop_count_q <= pop_count_q + 32'd1;
      end
      if (m_valid && !m_ready) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign pop_count   = pop_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: self-checking bench for fifo_rd_streamer (BURST = 4).
// A queue stands in for the FIFO; every popped word is recorded and compared
// against expected words and against burst framing derived from the word's
// position since reset. Build with +define+FIFO_RD_STATS_EN to cover the
// statistics counters.
module tb_fifo_rd_streamer;
  import fifo_rd_pkg::*;

  localparam int DW    = 8;
  localparam int BURST = 4;

  // ---------------- clock / reset / DUT ----------------
  logic           rd_clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           fifo_empty = 1'b1;
  logic           fifo_read;
  logic [DW-1:0]  fifo_q = '0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [DW-1:0]  m_data;
  logic           m_last;
  logic           busy;
  fifo_rd_state_t state;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]    pop_count;
  logic [31:0]    stall_count;
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_rd_streamer #(
    .DWIDTH(DW),
    .BURST (BURST)
  ) dut (
    .rd_clk     (rd_clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_q     (fifo_q),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .state      (state)
`ifdef FIFO_RD_STATS_EN
    ,
    .pop_count  (pop_count),
    .stall_count(stall_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            pop_idx = 0;
  logic [DW-1:0] fifo_mem[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          got_last_q[$];
  logic          exp_last_q[$];
  int            got_cyc_q[$];
  logic          last_rd;
  logic          last_pop;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // One rd_clk cycle. Samples the handshake just before the edge, models the
  // FIFO (data appears one cycle after the read strobe) just after it.
  task automatic tick();
    #1;
    last_rd  = fifo_read;
    last_pop = m_valid && m_ready && !reset;
    if (last_pop) begin
      got_q.push_back(m_data);
      got_last_q.push_back(m_last);
      got_cyc_q.push_back(cyc);
      exp_last_q.push_back((pop_idx % BURST) == BURST - 1);
    end
    @(posedge rd_clk);
    cyc++;
    if (reset) pop_idx = 0;
    else if (last_pop) pop_idx++;
    #1;
    if (last_rd) begin
      n_checks++;
      if (fifo_mem.size() == 0) begin
        n_fail++;
        $display("FAIL underflow: fifo_read=1 while FIFO holds 0 words");
      end else begin
        fifo_q = fifo_mem.pop_front();
      end
    end
    fifo_empty = (fifo_mem.size() == 0);
  endtask

  task automatic load_word(input logic [DW-1:0] w);
    fifo_mem.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_got();
    got_q.delete();
    got_last_q.delete();
    got_cyc_q.delete();
    exp_last_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until_idle();
    for (int i = 0; i < 30 && (busy || state != IDLE); i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_read: got %0b want 0", fifo_read); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
    n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %0b want 0", m_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0h want 0", m_data); end
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
    reset = 1'b0;
    tick();
    clear_got();
  endtask

  task automatic test_basic();
    int start;
    int rd_c[$];
    clear_got();
    for (int i = 0; i < 4; i++) load_word(DW'(8'h11 + i));
    enable = 1'b1; m_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_rd) rd_c.push_back(cyc - 1 - start);
    end
    n_checks++;
    if (rd_c.size() != 4 || rd_c[0] != 0 || rd_c[rd_c.size()-1] != 3) begin
      n_fail++; $display("FAIL basic_reads: got %0d reads, want 4 on cycles 0..3", rd_c.size());
    end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d words want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL basic_data[%0d]: got %0h want %0h", i, got_q[i], e); end
      n_checks++; if (got_cyc_q[i] - start != 2 + i) begin n_fail++; $display("FAIL basic_timing[%0d]: got cycle %0d want %0d", i, got_cyc_q[i] - start, 2 + i); end
      n_checks++; if (got_last_q[i] !== exp_last_q[i]) begin n_fail++; $display("FAIL basic_last[%0d]: got %0b want %0b", i, got_last_q[i], exp_last_q[i]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL basic_state_end: got %0d want %0d", state, IDLE); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[10];
    int nrd;
    int budget;
    clear_got();
    for (int i = 0; i < 10; i++) begin
      w[i] = DW'($urandom_range(0, 255));
      load_word(w[i]);
    end
    enable = 1'b1; m_ready = 1'b0; nrd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_rd) nrd++;
      if (i >= 2) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== w[0]) begin
          n_fail++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%0h want valid=1 data=%0h", i, m_valid, m_data, w[0]);
        end
      end
    end
    n_checks++; if (nrd != 2) begin n_fail++; $display("FAIL bp_reads: got %0d reads want 2", nrd); end
    m_ready = 1'b1;
    budget = 0;
    while (got_q.size() < 10 && budget < 40) begin tick(); budget++; end
    n_checks++; if (got_q.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d words want 10", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL bp_data[%0d]: got %0h want %0h", i, got_q[i], e); end
      n_checks++; if (got_cyc_q[i] != got_cyc_q[0] + i) begin n_fail++; $display("FAIL bp_gap[%0d]: got cycle %0d want %0d", i, got_cyc_q[i], got_cyc_q[0] + i); end
      n_checks++; if (got_last_q[i] !== exp_last_q[i]) begin n_fail++; $display("FAIL bp_last[%0d]: got %0b want %0b", i, got_last_q[i], exp_last_q[i]); end
    end
    run_until_idle();
  endtask

  task automatic test_burst();
    int budget;
    int nlast;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    pulse_reset();
    clear_got();
    for (int i = 0; i < 9; i++) load_word(DW'($urandom_range(0, 255)));
    enable = 1'b1; budget = 0; prev_stall = 1'b0; prev_data = '0;
    while (got_q.size() < 9 && budget < 200) begin
      m_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          n_fail++; $display("FAIL burst_stable: got valid=%0b data=%0h want valid=1 data=%0h", m_valid, m_data, prev_data);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
      budget++;
    end
    m_ready = 1'b1;
    n_checks++; if (got_q.size() != 9) begin n_fail++; $display("FAIL burst_count: got %0d words want 9", got_q.size()); end
    nlast = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      logic [DW-1:0] e;
      logic          el;
      e  = exp_q.pop_front();
      el = ((i % BURST) == BURST - 1);
      if (got_last_q[i]) nlast++;
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL burst_data[%0d]: got %0h want %0h", i, got_q[i], e); end
      n_checks++; if (got_last_q[i] !== el) begin n_fail++; $display("FAIL burst_last[%0d]: got %0b want %0b", i, got_last_q[i], el); end
    end
    n_checks++; if (nlast != 2) begin n_fail++; $display("FAIL burst_nlast: got %0d want 2", nlast); end
    run_until_idle();
  endtask

  task automatic test_drain();
    logic [DW-1:0] w[5];
    int nrd;
    int budget;
    clear_got();
    for (int i = 0; i < 5; i++) begin
      w[i] = DW'($urandom_range(0, 255));
      load_word(w[i]);
    end
    enable = 1'b1; m_ready = 1'b0; nrd = 0;
    tick(); if (last_rd) nrd++;
    tick(); if (last_rd) nrd++;
    n_checks++; if (nrd != 2) begin n_fail++; $display("FAIL drain_pre_reads: got %0d want 2", nrd); end
    enable = 1'b0;
    tick(); if (last_rd) nrd++;
    n_checks++; if (state !== DRAIN) begin n_fail++; $display("FAIL drain_state: got %0d want %0d", state, DRAIN); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %0b want 1", busy); end
    m_ready = 1'b1; budget = 0;
    while (busy && budget < 10) begin tick(); if (last_rd) nrd++; budget++; end
    tick(); if (last_rd) nrd++;
    n_checks++; if (nrd != 2) begin n_fail++; $display("FAIL drain_no_read: got %0d reads want 2", nrd); end
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL drain_idle: got %0d want %0d", state, IDLE); end
    n_checks++; if (fifo_mem.size() != 3) begin n_fail++; $display("FAIL drain_left: got %0d words in FIFO want 3", fifo_mem.size()); end
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL drain_count: got %0d words want 2", got_q.size()); end
    enable = 1'b1; budget = 0;
    while (got_q.size() < 5 && budget < 30) begin tick(); budget++; end
    n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL drain_resume_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, got_q[i], e); end
      n_checks++; if (got_last_q[i] !== exp_last_q[i]) begin n_fail++; $display("FAIL drain_last[%0d]: got %0b want %0b", i, got_last_q[i], exp_last_q[i]); end
    end
    run_until_idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w[4];
    int budget;
    clear_got();
    for (int i = 0; i < 4; i++) begin
      w[i] = DW'($urandom_range(0, 255));
      fifo_mem.push_back(w[i]);
    end
    fifo_empty = 1'b0;
    enable = 1'b1; m_ready = 1'b0;
    repeat (4) tick();
    n_checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_full: got valid=%0b busy=%0b want 1 1", m_valid, busy); end
    n_checks++; if (fifo_mem.size() != 2) begin n_fail++; $display("FAIL rmid_reads: got %0d left want 2", fifo_mem.size()); end
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", m_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d want %0d", state, IDLE); end
    // The two buffered words are lost; only the two still in the FIFO follow.
    exp_q.push_back(w[2]);
    exp_q.push_back(w[3]);
    enable = 1'b1; m_ready = 1'b1; budget = 0;
    while (got_q.size() < 2 && budget < 20) begin tick(); budget++; end
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL rmid_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL rmid_data[%0d]: got %0h want %0h", i, got_q[i], e); end
      n_checks++; if (got_last_q[i] !== exp_last_q[i]) begin n_fail++; $display("FAIL rmid_last[%0d]: got %0b want %0b", i, got_last_q[i], exp_last_q[i]); end
    end
    run_until_idle();
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    int budget;
    pulse_reset();
    clear_got();
    n_checks++; if (pop_count !== 32'd0 || stall_count !== 32'd0) begin n_fail++; $display("FAIL stats_reset0: got pop=%0d stall=%0d want 0 0", pop_count, stall_count); end
    for (int i = 0; i < 5; i++) load_word(DW'($urandom_range(0, 255)));
    enable = 1'b1; m_ready = 1'b0; budget = 0;
    while (!m_valid && budget < 10) begin tick(); budget++; end
    repeat (3) tick();
    m_ready = 1'b1; budget = 0;
    while (got_q.size() < 5 && budget < 30) begin tick(); budget++; end
    run_until_idle();
    n_checks++; if (pop_count !== 32'd5) begin n_fail++; $display("FAIL stats_pop: got %0d want 5", pop_count); end
    n_checks++; if (stall_count !== 32'd3) begin n_fail++; $display("FAIL stats_stall: got %0d want 3", stall_count); end
    pulse_reset();
    n_checks++; if (pop_count !== 32'd0 || stall_count !== 32'd0) begin n_fail++; $display("FAIL stats_reset: got pop=%0d stall=%0d want 0 0", pop_count, stall_count); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_burst();
    test_drain();
    test_reset_mid();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
